sdram_multiport_arbiter: RTL and testbench
==========================================

Name: sdram_multiport_arbiter

Overview:
N-port burst arbiter in the SDRAM clock domain, placed between per-client command/data streams and the SDRAM controller command interface. It generalises the fixed two-client reader/writer arbitration to NUM_PORTS clients, each able to issue both reads and writes. It forwards per-beat write data and DQM from the granted port. It routes read-response bursts back to the issuing port through an in-order tag FIFO.

Parameters:
NUM_PORTS, 4, number of client ports (2..8)
ADDR_WIDTH, 24, burst start address width
DATA_WIDTH, 16, data beat width; must be a multiple of 8
DQM_WIDTH, DATA_WIDTH/8, byte-mask bits per beat
BURST_LEN, 8, beats per read or write burst
TAG_DEPTH, 8, maximum outstanding read bursts; power of 2

Ports:
clk  in  1  SDRAM-domain clock
rstn  in  1  asynchronous active-low reset
port_cmd_valid_i  in  NUM_PORTS  per-port command request
port_cmd_ready_o  out  NUM_PORTS  per-port command accept
port_cmd_we_i  in  NUM_PORTS  1=write burst, 0=read burst
port_cmd_addr_i  in  NUM_PORTS*ADDR_WIDTH  flattened addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
port_wdata_valid_i  in  NUM_PORTS  write beat valid
port_wdata_ready_o  out  NUM_PORTS  write beat accept
port_wdata_i  in  NUM_PORTS*DATA_WIDTH  flattened write data
port_wdqm_i  in  NUM_PORTS*DQM_WIDTH  flattened byte masks; 1=masked
port_rsp_valid_o  out  NUM_PORTS  read beat valid
port_rsp_last_o  out  NUM_PORTS  last beat of burst
port_rsp_data_o  out  DATA_WIDTH  shared read data; qualified by port_rsp_valid_o
port_rsp_ready_i  in  NUM_PORTS  read beat accept
mem_cmd_valid_o / mem_cmd_ready_i  out/in  1  controller command handshake
mem_cmd_we_o  out  1  command type
mem_cmd_addr_o  out  ADDR_WIDTH  command address
mem_wdata_valid_o / mem_wdata_ready_i  out/in  1  write beat handshake
mem_wdata_o  out  DATA_WIDTH  write beat data
mem_wdqm_o  out  DQM_WIDTH  write beat mask
mem_rsp_valid_i / mem_rsp_ready_o  in/out  1  read beat handshake
mem_rsp_last_i  in  1  last read beat
mem_rsp_data_i  in  DATA_WIDTH  read beat data
grant_o  out  $clog2(NUM_PORTS)  current or last granted port (diagnostic)
tag_count_o  out  $clog2(TAG_DEPTH)+1  outstanding read bursts
error_orphan_o  out  1  sticky: response arrived with tag FIFO empty
error_clear_i  in  1  clears error_orphan_o

Behaviour:
- Reset (async, rstn=0): state ARB_IDLE, rr_ptr=0, grant_o=0, tag FIFO empty, beat counter 0. All valid/ready outputs are 0, error_orphan_o=0, tag_count_o=0.
- Eligible port p: port_cmd_valid_i[p]=1, and, if it requests a read, the tag FIFO is not full.
- ARB_IDLE: pick the first eligible port searching upward from rr_ptr with wrap. Latch its index into grant_o, its we, and its addr. Go to ARB_CMD. If no port is eligible, stay.
- ARB_CMD: mem_cmd_valid_o=1 with the latched we/addr. port_cmd_ready_o[grant]=mem_cmd_ready_i; all other bits are 0. The port must hold its command until accepted.
  - On handshake of a read: push grant onto the tag FIFO, set rr_ptr=(grant+1) mod NUM_PORTS, go to ARB_IDLE.
  - On handshake of a write: clear the beat counter, go to ARB_WDATA.
- Minimum latency: request cycle n gives mem_cmd_valid_o at n+1. Back-to-back read bursts issue at most every 2 cycles.
- ARB_WDATA: combinational pass-through of the granted port's lanes.
  - mem_wdata_valid_o=port_wdata_valid_i[grant]; mem_wdata_o and mem_wdqm_o come from the granted lanes.
  - port_wdata_ready_o[grant]=mem_wdata_ready_i; all other ports see 0.
  - Count handshakes. On the BURST_LEN-th beat set rr_ptr=grant+1 and go to ARB_IDLE.
  - No timeout: a stalled port holds the bus.
- Response routing: head = tag FIFO head.
  - Port head receives mem_rsp_valid_i, mem_rsp_last_i and data; mem_rsp_ready_o=port_rsp_ready_i[head].
  - A handshake with mem_rsp_last_i=1 pops the tag.
  - A push and a pop in the same cycle are allowed; the count is unchanged.
  - Response routing runs concurrently with the command FSM.
- Orphan response (mem_rsp_valid_i=1 while the FIFO is empty): mem_rsp_ready_o=1, so the beat is dropped. error_orphan_o sets on the next edge. error_clear_i has priority over a simultaneous set.
- Tag FIFO full (TAG_DEPTH outstanding): reads are ineligible; writes proceed.
- Reset mid-burst aborts with no replay. The controller shares the same reset.

Optional Feature:
SDRAM_ARB_PRIO0_EN
- Defined: in ARB_IDLE, eligible port 0 always wins over the round-robin choice. A port-0 grant leaves rr_ptr unchanged, so the other ports keep their rotation. Intended for a real-time video port.
- Undefined: pure round-robin as specified above.

Decomposition:
- sdram_pkg additions: arb_state_t enum (ARB_IDLE, ARB_CMD, ARB_WDATA) and a helper function rr_pick(req, ptr) returning the first set bit at or above ptr with wrap.
- One sub-module: sdram_tag_fifo, a synchronous FIFO of width $clog2(NUM_PORTS) and depth TAG_DEPTH, with full/empty/count outputs.

Test Plan:
- All 4 ports request reads at 0x000100/0x000200/0x000300/0x000400 together -> grants in order 0,1,2,3; tag_count_o reaches 4. Responses of 8 beats each are delivered to ports 0..3 in order, each with last on beat 8.
- Port 2 writes 8 beats 0xA000..0xA007 with DQM=01 on beat 3 -> mem_wdata_o matches exactly, mem_wdqm_o=01 only on beat 3, and the other ports' wdata_ready stays 0.
- 9 reads from port 1 with no responses (TAG_DEPTH=8) -> the 9th is blocked; a port-3 write is still granted; after one response burst the 9th read issues.
- mem_rsp_valid_i pulse with no outstanding reads -> the beat is dropped and error_orphan_o=1. error_clear_i returns it to 0; asserted together with a new orphan, it stays 0.
- rstn low mid-write on beat 4 -> all outputs 0 immediately; after release, state ARB_IDLE and rr_ptr=0.
- With SDRAM_ARB_PRIO0_EN defined and ports 0 and 3 continuously requesting -> port 0 gets every grant while requesting; port 3 is granted on the first cycle port 0 drops its request.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM multiport arbiter.
// Provides the arbiter state enum and the round-robin pick helper.
package sdram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_CMD   = 2'd1,
    ARB_WDATA = 2'd2
  } arb_state_t;

  // First set bit of req at or above ptr, wrapping within n ports (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (!found && (i < n) && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order tag FIFO holding the port index of each outstanding read burst.
// Ports: push/push_data enqueue, pop dequeues, head is the oldest entry,
// full/empty/count report occupancy. Push on full and pop on empty are ignored.
module sdram_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign head    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (do_pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_multiport_arbiter.sv
// N-port burst arbiter in front of the SDRAM controller command interface.
// Ports: per-port command (valid/ready/we/addr), write beat (valid/ready/data/dqm)
// and read response (valid/last/data/ready) lanes; controller-side command, write
// and response handshakes; grant_o, tag_count_o and sticky error_orphan_o.
// Optional macro SDRAM_ARB_PRIO0_EN: eligible port 0 always wins arbitration and
// its grants leave the round-robin pointer untouched.
module sdram_multiport_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DQM_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_PORTS-1:0]            port_cmd_valid_i,
  output logic [NUM_PORTS-1:0]            port_cmd_ready_o,
  input  logic [NUM_PORTS-1:0]            port_cmd_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_cmd_addr_i,
  input  logic [NUM_PORTS-1:0]            port_wdata_valid_i,
  output logic [NUM_PORTS-1:0]            port_wdata_ready_o,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata_i,
  input  logic [NUM_PORTS*DQM_WIDTH-1:0]  port_wdqm_i,
  output logic [NUM_PORTS-1:0]            port_rsp_valid_o,
  output logic [NUM_PORTS-1:0]            port_rsp_last_o,
  output logic [DATA_WIDTH-1:0]           port_rsp_data_o,
  input  logic [NUM_PORTS-1:0]            port_rsp_ready_i,
  output logic                            mem_cmd_valid_o,
  input  logic                            mem_cmd_ready_i,
  output logic                            mem_cmd_we_o,
  output logic [ADDR_WIDTH-1:0]           mem_cmd_addr_o,
  output logic                            mem_wdata_valid_o,
  input  logic                            mem_wdata_ready_i,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  output logic [DQM_WIDTH-1:0]            mem_wdqm_o,
  input  logic                            mem_rsp_valid_i,
  output logic                            mem_rsp_ready_o,
  input  logic                            mem_rsp_last_i,
  input  logic [DATA_WIDTH-1:0]           mem_rsp_data_i,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_o,
  output logic [$clog2(TAG_DEPTH):0]      tag_count_o,
  output logic                            error_orphan_o,
  input  logic                            error_clear_i
);
  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_t             state_q;
  logic [GW-1:0]          rr_ptr_q, grant_q, pick, next_ptr, head;
  logic                   we_q, err_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BW-1:0]          beat_q;
  logic [NUM_PORTS-1:0]   elig;
  logic                   fifo_full, fifo_empty, push, pop, cmd_hs, wd_hs;

  assign mem_cmd_valid_o = (state_q == ARB_CMD);
  assign mem_cmd_we_o    = we_q;
  assign mem_cmd_addr_o  = addr_q;
  assign grant_o         = grant_q;
  assign error_orphan_o  = err_q;

  // Reads need a free tag slot; writes are always eligible.
  assign elig   = port_cmd_valid_i & (port_cmd_we_i | {NUM_PORTS{!fifo_full}});
  assign cmd_hs = (state_q == ARB_CMD) && mem_cmd_ready_i;
  assign wd_hs  = (state_q == ARB_WDATA) && port_wdata_valid_i[grant_q] && mem_wdata_ready_i;
  assign push   = cmd_hs && !we_q;
  assign pop    = !fifo_empty && mem_rsp_valid_i && mem_rsp_last_i && port_rsp_ready_i[head];

  // Arbitration choice for the next grant.
  always_comb begin
    pick = GW'(rr_pick(8'(elig), 3'(rr_ptr_q), NUM_PORTS));
`ifdef SDRAM_ARB_PRIO0_EN
    if (elig[0]) pick = '0;
`endif
  end

  // Round-robin pointer after the current grant completes.
  always_comb begin
    next_ptr = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);
`ifdef SDRAM_ARB_PRIO0_EN
    if (grant_q == '0) next_ptr = rr_ptr_q;
`endif
  end

  // Command FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      beat_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|elig) begin
            grant_q <= pick;
            we_q    <= port_cmd_we_i[pick];
            addr_q  <= port_cmd_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            state_q <= ARB_CMD;
          end
        end
        ARB_CMD: begin
          if (mem_cmd_ready_i) begin
            if (we_q) begin
              beat_q  <= '0;
              state_q <= ARB_WDATA;
            end else begin
              rr_ptr_q <= next_ptr;
              state_q  <= ARB_IDLE;
            end
          end
        end
        ARB_WDATA: begin
          if (wd_hs) begin
            if (beat_q == BW'(BURST_LEN - 1)) begin
              beat_q   <= '0;
              rr_ptr_q <= next_ptr;
              state_q  <= ARB_IDLE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Sticky orphan-response flag; clear wins over a simultaneous set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                err_q <= 1'b0;
    else if (error_clear_i)                   err_q <= 1'b0;
    else if (mem_rsp_valid_i && fifo_empty)   err_q <= 1'b1;
  end

  // Command-accept and write-beat pass-through for the granted port.
  always_comb begin
    port_cmd_ready_o   = '0;
    port_wdata_ready_o = '0;
    mem_wdata_valid_o  = 1'b0;
    mem_wdata_o        = '0;
    mem_wdqm_o         = '0;
    if (state_q == ARB_CMD) port_cmd_ready_o[grant_q] = mem_cmd_ready_i;
    if (state_q == ARB_WDATA) begin
      mem_wdata_valid_o           = port_wdata_valid_i[grant_q];
      mem_wdata_o                 = port_wdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
      mem_wdqm_o                  = port_wdqm_i[int'(grant_q)*DQM_WIDTH +: DQM_WIDTH];
      port_wdata_ready_o[grant_q] = mem_wdata_ready_i;
    end
  end

  // Response routing to the port at the tag FIFO head; orphans are accepted and dropped.
  always_comb begin
    port_rsp_valid_o = '0;
    port_rsp_last_o  = '0;
    port_rsp_data_o  = mem_rsp_data_i;
    mem_rsp_ready_o  = mem_rsp_valid_i;
    if (!fifo_empty) begin
      port_rsp_valid_o[head] = mem_rsp_valid_i;
      port_rsp_last_o[head]  = mem_rsp_last_i;
      mem_rsp_ready_o        = port_rsp_ready_i[head];
    end
  end

  sdram_tag_fifo #(
    .WIDTH (GW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (grant_q),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (tag_count_o)
  );

endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// Directed bench for sdram_multiport_arbiter (4 ports, 24-bit addr, 16-bit data).
module tb_sdram_multiport_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 2;

  logic clk = 1'b0;
  logic rstn;
  logic [NP-1:0]    cmd_valid, cmd_ready, cmd_we, wvalid, wready;
  logic [NP-1:0]    rsp_valid, rsp_last, rsp_ready;
  logic [NP*AW-1:0] cmd_addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*MW-1:0] wdqm;
  logic [DW-1:0]    rsp_data;
  logic             m_cmd_valid, m_cmd_ready, m_cmd_we;
  logic [AW-1:0]    m_cmd_addr;
  logic             m_wvalid, m_wready;
  logic [DW-1:0]    m_wdata;
  logic [MW-1:0]    m_wdqm;
  logic             m_rvalid, m_rready, m_rlast;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       grant;
  logic [3:0]       tag_count;
  logic             err, err_clear;

  always #5 clk = ~clk;

  sdram_multiport_arbiter dut (
    .clk                (clk),
    .rstn               (rstn),
    .port_cmd_valid_i   (cmd_valid),
    .port_cmd_ready_o   (cmd_ready),
    .port_cmd_we_i      (cmd_we),
    .port_cmd_addr_i    (cmd_addr),
    .port_wdata_valid_i (wvalid),
    .port_wdata_ready_o (wready),
    .port_wdata_i       (wdata),
    .port_wdqm_i        (wdqm),
    .port_rsp_valid_o   (rsp_valid),
    .port_rsp_last_o    (rsp_last),
    .port_rsp_data_o    (rsp_data),
    .port_rsp_ready_i   (rsp_ready),
    .mem_cmd_valid_o    (m_cmd_valid),
    .mem_cmd_ready_i    (m_cmd_ready),
    .mem_cmd_we_o       (m_cmd_we),
    .mem_cmd_addr_o     (m_cmd_addr),
    .mem_wdata_valid_o  (m_wvalid),
    .mem_wdata_ready_i  (m_wready),
    .mem_wdata_o        (m_wdata),
    .mem_wdqm_o         (m_wdqm),
    .mem_rsp_valid_i    (m_rvalid),
    .mem_rsp_ready_o    (m_rready),
    .mem_rsp_last_i     (m_rlast),
    .mem_rsp_data_i     (m_rdata),
    .grant_o            (grant),
    .tag_count_o        (tag_count),
    .error_orphan_o     (err),
    .error_clear_i      (err_clear)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  cmd_valid;
    logic        exp_cvalid;
    logic [1:0]  exp_grant;
    logic [23:0] exp_addr;
    logic [3:0]  exp_cready;
    logic [3:0]  exp_tags;
  } vec_t;

  vec_t vecs [9];
  int   g [4];
  int   exp_g [4];
  int   hs, n;
  logic found;

  initial begin
    vecs[0] = '{4'b1111, 1'b0, 2'd0, 24'h000000, 4'b0000, 4'd0};
    vecs[1] = '{4'b1111, 1'b1, 2'd0, 24'h000100, 4'b0001, 4'd0};
    vecs[2] = '{4'b1110, 1'b0, 2'd0, 24'h000100, 4'b0000, 4'd1};
    vecs[3] = '{4'b1110, 1'b1, 2'd1, 24'h000200, 4'b0010, 4'd1};
    vecs[4] = '{4'b1100, 1'b0, 2'd1, 24'h000200, 4'b0000, 4'd2};
    vecs[5] = '{4'b1100, 1'b1, 2'd2, 24'h000300, 4'b0100, 4'd2};
    vecs[6] = '{4'b1000, 1'b0, 2'd2, 24'h000300, 4'b0000, 4'd3};
    vecs[7] = '{4'b1000, 1'b1, 2'd3, 24'h000400, 4'b1000, 4'd3};
    vecs[8] = '{4'b0000, 1'b0, 2'd3, 24'h000400, 4'b0000, 4'd4};
`ifdef SDRAM_ARB_PRIO0_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 3, 0, 3};
`endif

    rstn = 1'b0; cmd_valid = '0; cmd_we = '0; cmd_addr = '0; wvalid = '0;
    wdata = '0; wdqm = '0; rsp_ready = '0; m_cmd_ready = 1'b0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_valid", m_cmd_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_rsp_ready", m_rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tags", tag_count, 0);
    chk("rst_err", err, 0);
    rstn = 1'b1;

    // Four simultaneous reads, round-robin order, tags accumulate.
    for (int p = 0; p < 4; p++) cmd_addr[p*AW +: AW] = 24'(32'h100 * (p + 1));
    m_cmd_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cmd_valid = vecs[i].cmd_valid;
      #1;
      chk($sformatf("v%0d_cmd_valid", i), m_cmd_valid, vecs[i].exp_cvalid);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].exp_grant);
      chk($sformatf("v%0d_addr", i), m_cmd_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_cmd_ready", i), cmd_ready, vecs[i].exp_cready);
      chk($sformatf("v%0d_tags", i), tag_count, vecs[i].exp_tags);
      if (vecs[i].exp_cvalid) chk($sformatf("v%0d_we", i), m_cmd_we, 0);
      tick();
    end

    // Four response bursts routed to ports 0..3 in order.
    rsp_ready = 4'hF;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        m_rvalid = 1'b1;
        m_rlast  = (k == 7);
        m_rdata  = 16'(32'hD000 + b * 16 + k);
        #1;
        if (k == 0) chk("rsp_tags", tag_count, 64'(4 - b));
        chk("rsp_valid", rsp_valid, 64'(1 << b));
        chk("rsp_last", rsp_last, (k == 7) ? 64'(1 << b) : 64'h0);
        chk("rsp_data", rsp_data, 64'(32'hD000 + b * 16 + k));
        chk("rsp_ready", m_rready, 1);
        tick();
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    #1;
    chk("rsp_drained", tag_count, 0);
    tick();

    // Port 2 write burst with a masked byte on beat 3 and one stall on beat 5.
    cmd_valid = 4'b0100; cmd_we = 4'b0100; cmd_addr[2*AW +: AW] = 24'h000500;
    wvalid = 4'b1111; wdata = {NP*DW{1'b1}}; wdqm = {NP*MW{1'b1}}; m_wready = 1'b1;
    #1;
    chk("wr_idle", m_cmd_valid, 0);
    tick();
    #1;
    chk("wr_cmd_valid", m_cmd_valid, 1);
    chk("wr_cmd_we", m_cmd_we, 1);
    chk("wr_cmd_addr", m_cmd_addr, 24'h000500);
    chk("wr_grant", grant, 2);
    chk("wr_cmd_ready", cmd_ready, 4'b0100);
    tick();
    cmd_valid = '0;
    for (int k = 0; k < 8; k++) begin
      wdata[2*DW +: DW] = 16'(32'hA000 + k);
      wdqm[2*MW +: MW]  = (k == 3) ? 2'b01 : 2'b00;
      if (k == 5) begin
        m_wready = 1'b0;
        #1;
        chk("wr_stall_ready", wready, 0);
        chk("wr_stall_valid", m_wvalid, 1);
        tick();
        m_wready = 1'b1;
      end
      #1;
      chk($sformatf("wr_data%0d", k), m_wdata, 64'(32'hA000 + k));
      chk($sformatf("wr_dqm%0d", k), m_wdqm, (k == 3) ? 2'b01 : 2'b00);
      chk($sformatf("wr_valid%0d", k), m_wvalid, 1);
      chk($sformatf("wr_ready%0d", k), wready, 4'b0100);
      tick();
    end
    #1;
    chk("wr_done_valid", m_wvalid, 0);
    chk("wr_done_ready", wready, 0);
    tick();
    wvalid = '0; cmd_we = '0;

    // Port 1 fills the tag FIFO; the 9th read must wait.
    cmd_valid = 4'b0010; cmd_addr[1*AW +: AW] = 24'h000600;
    hs = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cmd_ready[1]) hs++;
      tick();
    end
    #1;
    chk("full_handshakes", hs, 8);
    chk("full_tags", tag_count, 8);
    chk("full_blocked", m_cmd_valid, 0);
    tick();

    // A port 3 write still proceeds while reads are blocked.
    cmd_valid = 4'b1010; cmd_we = 4'b1000; wvalid = 4'b1000;
    wdata[3*DW +: DW] = 16'h3333;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1;
      if (m_cmd_valid && grant == 2'd3) found = 1'b1;
      else tick();
    end
    chk("full_write_granted", found, 1);
    chk("full_write_we", m_cmd_we, 1);
    tick();
    cmd_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("full_write_ready", wready, 4'b1000);
      tick();
    end
    wvalid = '0; cmd_we = '0;

    // One response burst frees a tag and lets the 9th read issue.
    for (int k = 0; k < 8; k++) begin
      m_rvalid = 1'b1; m_rlast = (k == 7);
      #1;
      chk("full_rsp_port1", rsp_valid, 4'b0010);
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1;
      if (m_cmd_valid && grant == 2'd1) found = 1'b1;
      else tick();
    end
    chk("ninth_read_issued", found, 1);
    chk("ninth_read_tags_before", tag_count, 7);
    tick();
    cmd_valid = '0;
    #1;
    chk("ninth_read_tags_after", tag_count, 8);
    tick();

    // Drain the remaining eight bursts.
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 8; k++) begin
        m_rvalid = 1'b1; m_rlast = (k == 7);
        #1;
        if (k == 7) chk("drain_last", rsp_last, 4'b0010);
        tick();
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("drain_tags", tag_count, 0);
    tick();

    // Orphan response, sticky error, clear priority.
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    chk("orphan_ready", m_rready, 1);
    chk("orphan_no_route", rsp_valid, 0);
    chk("orphan_err_pre", err, 0);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("orphan_err_set", err, 1);
    tick();
    err_clear = 1'b1;
    #1;
    chk("orphan_err_sticky", err, 1);
    tick();
    m_rvalid = 1'b1;
    #1;
    chk("orphan_err_cleared", err, 0);
    tick();
    err_clear = 1'b0; m_rvalid = 1'b0;
    #1;
    chk("orphan_clear_wins", err, 0);
    tick();

    // Reset in the middle of a port 2 write burst.
    cmd_valid = 4'b0100; cmd_we = 4'b0100; wvalid = 4'b0100;
    wdata[2*DW +: DW] = 16'h5A5A; wdqm[2*MW +: MW] = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1;
      if (m_cmd_valid && grant == 2'd2) found = 1'b1;
      else tick();
    end
    chk("rstw_granted", found, 1);
    tick();
    cmd_valid = '0;
    for (int k = 0; k < 4; k++) begin
      #1;
      tick();
    end
    #1;
    chk("rstw_beat4_valid", m_wvalid, 1);
    rstn = 1'b0;
    #1;
    chk("rstw_wvalid", m_wvalid, 0);
    chk("rstw_wready", wready, 0);
    chk("rstw_wdata", m_wdata, 0);
    chk("rstw_cmd_valid", m_cmd_valid, 0);
    chk("rstw_cmd_ready", cmd_ready, 0);
    chk("rstw_grant", grant, 0);
    chk("rstw_tags", tag_count, 0);
    tick();
    rstn = 1'b1; wvalid = '0; cmd_we = '0; cmd_valid = 4'b0110;
    #1;
    chk("rstw_idle", m_cmd_valid, 0);
    tick();
    #1;
    chk("rstw_ptr_zero_valid", m_cmd_valid, 1);
    chk("rstw_ptr_zero_grant", grant, 1);
    tick();
    cmd_valid = '0;

    // Ports 0 and 3 both request continuously; then port 0 drops.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    cmd_valid = 4'b1001; cmd_we = '0;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      #1;
      if (cmd_ready != '0) begin
        g[n] = int'(grant);
        n++;
      end
      tick();
    end
    cmd_valid = 4'b1000;
    #1;
    tick();
    #1;
    chk("prio_count", n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("prio_grant%0d", i), g[i], exp_g[i]);
    chk("prio_drop_valid", m_cmd_valid, 1);
    chk("prio_drop_grant", grant, 3);
    tick();
    cmd_valid = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
